// File: rtl/counter_sequencer_if.sv
// -----------------------------------------------------------------------------
// counter_sequencer_if
// Bundles the operator controls and the display-side outputs of the run-control
// sequencer so the board top and the sequencer share one connection object.
//
// Signals:
//   btn_load_n, btn_start_n, btn_stop_n : raw active-low push-buttons (async)
//   dir      : 1 = count up, 0 = count down
//   wrap_en  : 1 = wrap at the terminal value, 0 = stop there
//   load_val : value taken by a load command
//   count    : current count value
//   state    : 00 IDLE, 01 LOAD, 10 RUN, 11 HOLD
//   running  : high exactly while in RUN
//   tc       : one-cycle terminal-count pulse
// Modports:
//   master : drives the controls, observes the outputs (board top / bench)
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface counter_sequencer_if #(
  parameter int WIDTH = 3
);
  logic             btn_load_n;
  logic             btn_start_n;
  logic             btn_stop_n;
  logic             dir;
  logic             wrap_en;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             running;
  logic             tc;

  modport master (
    output btn_load_n, btn_start_n, btn_stop_n, dir, wrap_en, load_val,
    input  count, state, running, tc
  );

  modport slave (
    input  btn_load_n, btn_start_n, btn_stop_n, dir, wrap_en, load_val,
    output count, state, running, tc
  );
endinterface

// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
// Run-control sequencer for the loadable display counter. Raw buttons are
// synchronised, debounced and turned into single-cycle press events; an FSM
// then sequences load / run / hold of a WIDTH-bit counter that steps on a
// prescaled tick.
//
// Ports:
//   clk   : board clock, rising edge
//   rst_n : asynchronous active-low reset
//   io    : counter_sequencer_if.slave (buttons, dir, wrap_en, load_val in;
//           count, state, running, tc out -- all outputs are registered)
// -----------------------------------------------------------------------------
module counter_sequencer #(
  parameter int WIDTH    = 3,
  parameter int TICK_DIV = 50000000,
  parameter int DEBOUNCE = 500000
) (
  input  logic               clk,
  input  logic               rst_n,
  counter_sequencer_if.slave io
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]    DB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_HOLD = 2'b11
  } state_t;

  // Button index: 0 = load, 1 = start, 2 = stop
  logic [2:0]    w_btn_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_db;
  logic [2:0]    r_press;
  logic [DW-1:0] r_db_cnt [3];

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_presc;
  logic             r_tc;
  logic             r_running;

  logic             w_ld;
  logic             w_start;
  logic             w_stop;
  logic             w_tick;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_step;

  assign w_btn_raw = {io.btn_stop_n, io.btn_start_n, io.btn_load_n};

  // Synchronise, debounce and edge-detect the three buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
      r_db    <= 3'b111;
      r_press <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= {DW{1'b0}};
      end
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= {DW{1'b0}};
        end else if (r_db_cnt[i] == DB_LAST) begin
          // This cycle is the DEBOUNCE-th consecutive mismatch: accept it.
          // Only a 1->0 acceptance is a press; releases raise no event.
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= {DW{1'b0}};
          r_press[i]  <= ~r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign w_ld    = r_press[0];
  assign w_start = r_press[1];
  assign w_stop  = r_press[2];
  assign w_tick  = (r_presc == TICK_LAST);
  assign w_term  = io.dir ? CNT_MAX : CNT_ZERO;
  // Modular step: at the terminal value this is exactly the wrapped value
  assign w_step  = io.dir ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));

  // Run-control FSM with registered count, prescaler, tc and running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_count   <= CNT_ZERO;
      r_presc   <= {PW{1'b0}};
      r_tc      <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_ld) begin
            r_state   <= ST_LOAD;
            r_count   <= io.load_val;
            r_running <= 1'b0;
          end else if (w_start) begin
            r_state   <= ST_RUN;
            r_presc   <= {PW{1'b0}};
            r_running <= 1'b1;
          end else begin
            r_state   <= r_state;
            r_running <= 1'b0;
          end
        end
        ST_LOAD: begin
          // Single-cycle state; events arriving now are dropped
          r_state   <= ST_HOLD;
          r_running <= 1'b0;
        end
        ST_RUN: begin
          // Commands take precedence over a coincident tick
          if (w_ld) begin
            r_state   <= ST_LOAD;
            r_count   <= io.load_val;
            r_running <= 1'b0;
          end else if (w_stop) begin
            r_state   <= ST_HOLD;
            r_running <= 1'b0;
          end else if (w_tick) begin
            r_presc <= {PW{1'b0}};
            if (r_count == w_term) begin
              r_tc <= 1'b1;
              if (io.wrap_en) begin
                r_count   <= w_step;
                r_running <= 1'b1;
              end else begin
                r_state   <= ST_HOLD;
                r_running <= 1'b0;
              end
            end else begin
              r_count   <= w_step;
              r_running <= 1'b1;
            end
          end else begin
            r_presc   <= r_presc + PW'(1);
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign io.count   = r_count;
  assign io.state   = r_state;
  assign io.running = r_running;
  assign io.tc      = r_tc;

endmodule

// File: tb/tb_counter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_sequencer
// Directed scenarios with literal expectations, followed by randomized button,
// direction, wrap and load activity, all compared every cycle against a
// behavioural model of the sequencer kept in this bench.
// -----------------------------------------------------------------------------
module tb_counter_sequencer;

  localparam int WIDTH    = 3;
  localparam int TICK_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int MAXV     = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       btn_n;   // {stop, start, load}
  logic             dir_s;
  logic             wrap_s;
  logic [WIDTH-1:0] lv_s;

  counter_sequencer_if #(.WIDTH(WIDTH)) bus ();

  assign bus.btn_load_n  = btn_n[0];
  assign bus.btn_start_n = btn_n[1];
  assign bus.btn_stop_n  = btn_n[2];
  assign bus.dir         = dir_s;
  assign bus.wrap_en     = wrap_s;
  assign bus.load_val    = lv_s;

  counter_sequencer #(
    .WIDTH   (WIDTH),
    .TICK_DIV(TICK_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States numbered as the output encoding: 0 IDLE, 1 LOAD, 2 RUN, 3 HOLD.
  int m_state;
  int m_count;
  int m_phase;   // cycles spent in RUN since entry, modulo TICK_DIV
  int m_tc;
  bit m_db [3];
  bit m_ev [3];  // press seen this edge, acted upon at the next edge
  bit rh [3][8]; // raw level sampled at the last 8 edges, [0] = newest

  task automatic model_reset();
    m_state = 0; m_count = 0; m_phase = 0; m_tc = 0;
    for (int b = 0; b < 3; b++) begin
      m_db[b] = 1'b1;
      m_ev[b] = 1'b0;
      for (int i = 0; i < 8; i++) rh[b][i] = 1'b1;
    end
  endtask

  task automatic model_step();
    bit ld, st, sp, all_diff;
    int term;
    ld = m_ev[0]; st = m_ev[1]; sp = m_ev[2];
    m_tc = 0;
    if (m_state == 1) begin
      m_state = 3;
    end else if (ld) begin
      m_state = 1;
      m_count = int'(lv_s);
    end else if (m_state == 2) begin
      if (sp) begin
        m_state = 3;
      end else if (m_phase == TICK_DIV - 1) begin
        m_phase = 0;
        term = dir_s ? MAXV : 0;
        if (m_count == term) begin
          m_tc = 1;
          if (wrap_s) m_count = dir_s ? 0 : MAXV;
          else        m_state = 3;
        end else begin
          m_count = dir_s ? m_count + 1 : m_count - 1;
        end
      end else begin
        m_phase++;
      end
    end else if (st) begin
      m_state = 2;
      m_phase = 0;
    end
    // A level is accepted once DEBOUNCE consecutive synchronised samples
    // (raw delayed by two edges) all disagree with the accepted level.
    for (int b = 0; b < 3; b++) begin
      for (int i = 7; i > 0; i--) rh[b][i] = rh[b][i-1];
      rh[b][0] = btn_n[b];
      all_diff = 1'b1;
      for (int i = 2; i < 2 + DEBOUNCE; i++) begin
        if (rh[b][i] == m_db[b]) all_diff = 1'b0;
      end
      m_ev[b] = 1'b0;
      if (all_diff) begin
        m_ev[b] = m_db[b];
        m_db[b] = ~m_db[b];
      end
    end
  endtask

  // Compare process: advance the model on each edge, check 1 time unit later
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check("count",   int'(bus.count),   m_count);
    check("state",   int'(bus.state),   m_state);
    check("running", int'(bus.running), int'(m_state == 2));
    check("tc",      int'(bus.tc),      m_tc);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_btn(input logic [2:0] v);
    @(negedge clk);
    btn_n = v;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n = 1'b0; btn_n = 3'b111; dir_s = 1'b1; wrap_s = 1'b1; lv_s = 3'd0;
    edges(3);
    check("rst_count", int'(bus.count), 0);
    check("rst_state", int'(bus.state), 0);
    check("rst_tc",    int'(bus.tc), 0);
    @(negedge clk) rst_n = 1'b1;
    edges(10);
    check("idle_quiet", int'(bus.state), 0);

    // 2-cycle glitch on start: ignored
    drive_btn(3'b101);
    repeat (2) @(negedge clk);
    btn_n = 3'b111;
    edges(10);
    check("glitch_state", int'(bus.state), 0);

    // clean start: event 5 cycles after the fall, RUN one cycle later
    drive_btn(3'b101);
    edges(5);
    check("start_early", int'(bus.state), 0);
    edges(1);
    check("start_state",   int'(bus.state), 2);
    check("start_running", int'(bus.running), 1);
    edges(4);
    drive_btn(3'b111);

    // load 6
    drive_btn(3'b110);
    lv_s = 3'd6;
    edges(6);
    check("load_state", int'(bus.state), 1);
    check("load_count", int'(bus.count), 6);
    check("model_load", m_count, 6);
    edges(1);
    check("load_hold", int'(bus.state), 3);
    drive_btn(3'b111);

    // run up with wrap
    drive_btn(3'b101);
    dir_s = 1'b1; wrap_s = 1'b1;
    edges(6);
    check("up_run",   int'(bus.state), 2);
    check("up_count6", int'(bus.count), 6);
    edges(4);
    check("up_count7", int'(bus.count), 7);
    check("up_tc0",    int'(bus.tc), 0);
    edges(4);
    check("wrap_count0", int'(bus.count), 0);
    check("wrap_tc",     int'(bus.tc), 1);
    check("model_tc",    m_tc, 1);
    edges(1);
    check("wrap_tc_drop", int'(bus.tc), 0);
    edges(3);
    check("up_count1", int'(bus.count), 1);

    // down without wrap: 1 -> 0, then terminal hit stops in HOLD
    drive_btn(3'b111);
    dir_s = 1'b0; wrap_s = 1'b0;
    edges(4);
    check("down_count0", int'(bus.count), 0);
    check("down_tc0",    int'(bus.tc), 0);
    edges(4);
    check("term_tc",    int'(bus.tc), 1);
    check("term_state", int'(bus.state), 3);
    check("term_count", int'(bus.count), 0);
    edges(8);
    check("term_frozen", int'(bus.count), 0);

    // priority: load+stop+start together, coinciding with a tick
    drive_btn(3'b101);
    dir_s = 1'b1; wrap_s = 1'b1;
    edges(6);
    check("pri_run", int'(bus.state), 2);
    drive_btn(3'b111);
    edges(6);
    drive_btn(3'b000);
    lv_s = 3'd3;
    edges(5);
    check("pri_pre_count", int'(bus.count), 2);
    edges(1);
    check("pri_state", int'(bus.state), 1);
    check("pri_count", int'(bus.count), 3);
    check("pri_tc",    int'(bus.tc), 0);
    edges(1);
    check("pri_hold", int'(bus.state), 3);
    drive_btn(3'b111);
    edges(8);

    // stop at prescaler = 2, resume 20 cycles later
    drive_btn(3'b101);
    edges(3);
    drive_btn(3'b001);
    edges(3);
    check("sr_run", int'(bus.state), 2);
    edges(3);
    check("sr_hold",  int'(bus.state), 3);
    check("sr_count", int'(bus.count), 3);
    drive_btn(3'b111);
    edges(20);
    check("sr_frozen", int'(bus.count), 3);
    drive_btn(3'b101);
    edges(6);
    check("sr_rerun", int'(bus.state), 2);
    edges(3);
    check("sr_nostep", int'(bus.count), 3);
    edges(1);
    check("sr_step", int'(bus.count), 4);

    // asynchronous reset mid-run at count 5
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      edges(1);
      if (bus.count == 3'd5) found = 1'b1;
    end
    check("wait_count5", int'(found), 1);
    #2;
    rst_n = 1'b0;
    btn_n = 3'b111;
    #1;
    check("arst_count",   int'(bus.count), 0);
    check("arst_state",   int'(bus.state), 0);
    check("arst_running", int'(bus.running), 0);
    check("arst_tc",      int'(bus.tc), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edges(10);
    check("arst_quiet", int'(bus.state), 0);

    // randomized activity
    repeat (3000) begin
      @(negedge clk);
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 15) == 0) btn_n[b] = ~btn_n[b];
      end
      if ($urandom_range(0, 31) == 0) dir_s  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) wrap_s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) lv_s   = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
    end
    @(negedge clk) rst_n = 1'b1;
    edges(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
